// File: rtl/axis_monitor_pkg.sv
// AXI-Stream protocol monitor shared types.
// FSM states, error codes and keep popcount.
package axis_monitor_pkg;

  localparam int KEEP_MAX = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_VALID_DROP  = 2'd1,
    ERR_PAYLOAD_CHG = 2'd2,
    ERR_NULL_KEEP   = 2'd3
  } err_code_t;

  function automatic logic [7:0] popcount(
    input logic [KEEP_MAX-1:0] k
  );
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++)
      n = n + 8'(k[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_intfc.sv
// AXI-Stream bus bundle.
// Monitor modport observes every signal.
interface axis_intfc #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tid, tdest,
    output tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tid, tdest,
    input  tuser, tvalid,
    output tready
  );

  modport monitor (
    input tdata, tkeep, tid, tdest,
    input tuser, tvalid, tready
  );
endinterface

// File: rtl/axis_sat_counter.sv
// Saturating accumulator with sync clear.
// Sticks at all-ones instead of wrapping.
module axis_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] inc_amt,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + {1'b0, inc_amt};

  // accumulate, clamp on carry out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc_en)
      count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/axis_protocol_monitor.sv
// AXI-Stream handshake/payload checker.
// Counts traffic, flags sticky protocol errors.
module axis_protocol_monitor
  import axis_monitor_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DEST_WIDTH = 1,
  parameter int AXI_USER_WIDTH = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_intfc.monitor           mon,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] byte_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 err_valid_drop,
  output logic                 err_payload_chg,
  output logic                 err_null_keep,
  output logic [1:0]           first_err
);

  localparam int KW = AXI_DATA_WIDTH / 8;
  localparam int PW = AXI_DATA_WIDTH + KW
                    + AXI_ID_WIDTH + AXI_DEST_WIDTH
                    + AXI_USER_WIDTH;

  state_t  state, state_nxt;
  logic [PW-1:0] shadow, payload;
  logic    cap;

  logic    hs, stl;
  logic    e_drop, e_chg, e_null;

  logic [7:0]             pc;
  logic [CNT_WIDTH+7:0]   pc_w;
  logic [CNT_WIDTH+7:0]   cnt_max;
  logic [CNT_WIDTH-1:0]   byte_amt;

  assign payload = {mon.tdata, mon.tkeep, mon.tid,
                    mon.tdest, mon.tuser};

  assign hs  = mon.tvalid & mon.tready;
  assign stl = mon.tvalid & ~mon.tready;

  assign e_drop = (state == STALL) & ~mon.tvalid;
  assign e_chg  = (state == STALL) & mon.tvalid
                & (payload != shadow);
  assign e_null = hs & (mon.tkeep == '0);

  assign pc      = popcount(KEEP_MAX'(mon.tkeep));
  assign pc_w    = (CNT_WIDTH + 8)'(pc);
  assign cnt_max = (CNT_WIDTH + 8)'({CNT_WIDTH{1'b1}});
  assign byte_amt = (pc_w > cnt_max) ? '1
                  : CNT_WIDTH'(pc_w);

  // state and payload shadow registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      if (cap)
        shadow <= payload;
    end
  end

  // next state and shadow capture
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (stl) begin
            state_nxt = STALL;
            cap       = 1'b1;
          end
        end
        STALL: begin
          if (!mon.tvalid || hs)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // sticky error flags and first error code
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_valid_drop  <= 1'b0;
      err_payload_chg <= 1'b0;
      err_null_keep   <= 1'b0;
      first_err       <= ERR_NONE;
    end else if (clear) begin
      err_valid_drop  <= 1'b0;
      err_payload_chg <= 1'b0;
      err_null_keep   <= 1'b0;
      first_err       <= ERR_NONE;
    end else begin
      if (e_drop) err_valid_drop  <= 1'b1;
      if (e_chg)  err_payload_chg <= 1'b1;
      if (e_null) err_null_keep   <= 1'b1;
      if (first_err == ERR_NONE) begin
        unique case (1'b1)
          e_drop:  first_err <= ERR_VALID_DROP;
          e_chg:   first_err <= ERR_PAYLOAD_CHG;
          e_null:  first_err <= ERR_NULL_KEEP;
          default: first_err <= ERR_NONE;
        endcase
      end
    end
  end

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_beat (
    .clk     (aclk),
    .rst_n   (aresetn),
    .inc_en  (hs),
    .inc_amt (CNT_WIDTH'(1)),
    .clear   (clear),
    .count   (beat_count)
  );

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_byte (
    .clk     (aclk),
    .rst_n   (aresetn),
    .inc_en  (hs),
    .inc_amt (byte_amt),
    .clear   (clear),
    .count   (byte_count)
  );

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk     (aclk),
    .rst_n   (aresetn),
    .inc_en  (stl),
    .inc_amt (CNT_WIDTH'(1)),
    .clear   (clear),
    .count   (stall_count)
  );

endmodule

// File: tb/tb_axis_protocol_monitor.sv
// Directed bench for axis_protocol_monitor.
// Main DUT at CNT_WIDTH=32, second at 4.
module tb_axis_protocol_monitor;
  import axis_monitor_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic clear = 1'b0;
  logic clr4 = 1'b0;

  int checks = 0;
  int failures = 0;

  axis_intfc #(.DATA_W(64)) bus ();

  logic [31:0] beat_count, byte_count, stall_count;
  logic        err_valid_drop, err_payload_chg, err_null_keep;
  logic [1:0]  first_err;

  logic [3:0]  b4, y4, s4;
  logic        d4, c4, n4;
  logic [1:0]  f4;

  always #5 clk = ~clk;

  axis_protocol_monitor #(.CNT_WIDTH(32)) dut (
    .aclk            (clk),
    .aresetn         (aresetn),
    .mon             (bus.monitor),
    .clear           (clear),
    .beat_count      (beat_count),
    .byte_count      (byte_count),
    .stall_count     (stall_count),
    .err_valid_drop  (err_valid_drop),
    .err_payload_chg (err_payload_chg),
    .err_null_keep   (err_null_keep),
    .first_err       (first_err)
  );

  axis_protocol_monitor #(.CNT_WIDTH(4)) dut4 (
    .aclk            (clk),
    .aresetn         (aresetn),
    .mon             (bus.monitor),
    .clear           (clr4),
    .beat_count      (b4),
    .byte_count      (y4),
    .stall_count     (s4),
    .err_valid_drop  (d4),
    .err_payload_chg (c4),
    .err_null_keep   (n4),
    .first_err       (f4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.tvalid = 1'b0;
    bus.tready = 1'b0;
    bus.tdata  = '0;
    bus.tkeep  = 8'hFF;
    bus.tid    = '0;
    bus.tdest  = '0;
    bus.tuser  = '0;
  endtask

  task automatic do_clear();
    idle_bus();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    aresetn = 1'b0;
    #3;
    checks++;
    if (beat_count !== 32'd0 || byte_count !== 32'd0 ||
        stall_count !== 32'd0) begin
      $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0",
               beat_count, byte_count, stall_count);
      failures++;
    end
    checks++;
    if ({err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0) begin
      $display("FAIL reset_flags got=%b%b%b/%0d exp=000/0",
               err_valid_drop, err_payload_chg,
               err_null_keep, first_err);
      failures++;
    end
    checks++;
    if (dut.state !== IDLE) begin
      $display("FAIL reset_state got=%0d exp=0", dut.state);
      failures++;
    end
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_streaming();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      bus.tvalid = 1'b1;
      bus.tready = 1'b1;
      bus.tkeep  = 8'hFF;
      bus.tdata  = 64'(i + 1);
      step();
    end
    bus.tvalid = 1'b0;
    step();
    step();
    bus.tready = 1'b0;
    checks++;
    if (beat_count !== 32'd8) begin
      $display("FAIL stream_beats got=%0d exp=8", beat_count);
      failures++;
    end
    checks++;
    if (byte_count !== 32'd64) begin
      $display("FAIL stream_bytes got=%0d exp=64", byte_count);
      failures++;
    end
    checks++;
    if (stall_count !== 32'd0) begin
      $display("FAIL stream_stall got=%0d exp=0", stall_count);
      failures++;
    end
    checks++;
    if ({err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0) begin
      $display("FAIL stream_flags got=%b%b%b/%0d exp=000/0",
               err_valid_drop, err_payload_chg,
               err_null_keep, first_err);
      failures++;
    end
  endtask

  task automatic test_stall();
    do_clear();
    bus.tvalid = 1'b1;
    bus.tready = 1'b0;
    bus.tdata  = 64'hAB;
    bus.tkeep  = 8'hFF;
    step();
    step();
    step();
    checks++;
    if (dut.state !== STALL) begin
      $display("FAIL stall_state got=%0d exp=1", dut.state);
      failures++;
    end
    bus.tready = 1'b1;
    step();
    idle_bus();
    step();
    checks++;
    if (stall_count !== 32'd3 || beat_count !== 32'd1 ||
        byte_count !== 32'd8) begin
      $display("FAIL stall_cnt got=%0d/%0d/%0d exp=3/1/8",
               stall_count, beat_count, byte_count);
      failures++;
    end
    checks++;
    if ({err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0 || dut.state !== IDLE) begin
      $display("FAIL stall_flags got=%b%b%b/%0d st=%0d exp=000/0 st=0",
               err_valid_drop, err_payload_chg,
               err_null_keep, first_err, dut.state);
      failures++;
    end
  endtask

  task automatic test_payload_chg();
    do_clear();
    bus.tvalid = 1'b1;
    bus.tready = 1'b0;
    bus.tdata  = 64'h11;
    step();
    checks++;
    if (err_payload_chg !== 1'b0) begin
      $display("FAIL chg_early got=%b exp=0", err_payload_chg);
      failures++;
    end
    bus.tdata = 64'h22;
    step();
    checks++;
    if (err_payload_chg !== 1'b1 || first_err !== 2'd2) begin
      $display("FAIL chg_flag got=%b/%0d exp=1/2",
               err_payload_chg, first_err);
      failures++;
    end
    bus.tready = 1'b1;
    step();
    idle_bus();
    step();
    checks++;
    if (err_valid_drop !== 1'b0 || err_null_keep !== 1'b0) begin
      $display("FAIL chg_other got=%b%b exp=00",
               err_valid_drop, err_null_keep);
      failures++;
    end
  endtask

  task automatic test_valid_drop();
    do_clear();
    bus.tvalid = 1'b1;
    bus.tready = 1'b0;
    bus.tdata  = 64'h33;
    step();
    bus.tvalid = 1'b0;
    step();
    checks++;
    if (err_valid_drop !== 1'b1 || first_err !== 2'd1 ||
        dut.state !== IDLE) begin
      $display("FAIL drop_flag got=%b/%0d st=%0d exp=1/1 st=0",
               err_valid_drop, first_err, dut.state);
      failures++;
    end
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    bus.tkeep  = 8'h00;
    step();
    idle_bus();
    step();
    checks++;
    if (err_null_keep !== 1'b1 || first_err !== 2'd1) begin
      $display("FAIL null_after_drop got=%b/%0d exp=1/1",
               err_null_keep, first_err);
      failures++;
    end
    checks++;
    if (beat_count !== 32'd1 || byte_count !== 32'd0 ||
        err_payload_chg !== 1'b0) begin
      $display("FAIL null_cnt got=%0d/%0d/%b exp=1/0/0",
               beat_count, byte_count, err_payload_chg);
      failures++;
    end
  endtask

  task automatic test_saturation();
    idle_bus();
    clear = 1'b1;
    clr4  = 1'b1;
    step();
    clear = 1'b0;
    clr4  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.tvalid = 1'b1;
      bus.tready = 1'b1;
      bus.tkeep  = 8'h0F;
      bus.tdata  = 64'(i);
      step();
    end
    idle_bus();
    step();
    checks++;
    if (b4 !== 4'd15 || y4 !== 4'd15) begin
      $display("FAIL sat4 got=%0d/%0d exp=15/15", b4, y4);
      failures++;
    end
    checks++;
    if (beat_count !== 32'd20 || byte_count !== 32'd80) begin
      $display("FAIL sat32 got=%0d/%0d exp=20/80",
               beat_count, byte_count);
      failures++;
    end
  endtask

  task automatic test_clear_collision();
    do_clear();
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    bus.tkeep  = 8'hFF;
    step();
    bus.tkeep = 8'h00;
    step();
    checks++;
    if (first_err !== 2'd3 || beat_count !== 32'd2) begin
      $display("FAIL pre_clear got=%0d/%0d exp=3/2",
               first_err, beat_count);
      failures++;
    end
    bus.tkeep = 8'hFF;
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle_bus();
    checks++;
    if (beat_count !== 32'd0 || byte_count !== 32'd0 ||
        stall_count !== 32'd0) begin
      $display("FAIL clr_hs_cnt got=%0d/%0d/%0d exp=0/0/0",
               beat_count, byte_count, stall_count);
      failures++;
    end
    checks++;
    if ({err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0) begin
      $display("FAIL clr_flags got=%b%b%b/%0d exp=000/0",
               err_valid_drop, err_payload_chg,
               err_null_keep, first_err);
      failures++;
    end
    bus.tvalid = 1'b1;
    bus.tready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle_bus();
    checks++;
    if (dut.state !== IDLE || stall_count !== 32'd0) begin
      $display("FAIL clr_stall got=st%0d/%0d exp=st0/0",
               dut.state, stall_count);
      failures++;
    end
    step();
    checks++;
    if (err_valid_drop !== 1'b0) begin
      $display("FAIL clr_nodrop got=%b exp=0", err_valid_drop);
      failures++;
    end
  endtask

  task automatic test_reset_mid_stall();
    do_clear();
    bus.tvalid = 1'b1;
    bus.tready = 1'b0;
    bus.tdata  = 64'h77;
    step();
    step();
    checks++;
    if (stall_count !== 32'd2 || dut.state !== STALL) begin
      $display("FAIL pre_rst got=%0d st=%0d exp=2 st=1",
               stall_count, dut.state);
      failures++;
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (stall_count !== 32'd0 || beat_count !== 32'd0 ||
        byte_count !== 32'd0 || dut.state !== IDLE ||
        {err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0) begin
      $display("FAIL rst_mid got=%0d/%0d/%0d st=%0d f=%0d exp=0",
               stall_count, beat_count, byte_count,
               dut.state, first_err);
      failures++;
    end
    #1;
    aresetn    = 1'b1;
    bus.tdata  = 64'h55;
    bus.tready = 1'b1;
    step();
    idle_bus();
    step();
    checks++;
    if (beat_count !== 32'd1 || stall_count !== 32'd0 ||
        {err_valid_drop, err_payload_chg, err_null_keep,
         first_err} !== 5'b0) begin
      $display("FAIL post_rst got=%0d/%0d f=%0d exp=1/0/0",
               beat_count, stall_count, first_err);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_payload_chg();
    test_valid_drop();
    test_saturation();
    test_clear_collision();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
